qspi_phy_shifter: RTL and testbench
===================================

// Module: qspi_phy_shifter
// PURPOSE
//  Serial engine directly downstream of the QSPI core sequencer. Executes one transfer phase per start
//  (cmd/addr/dummy/data): generates SCLK (SPI mode 0), drives chip select, shifts data out MSB-first on
//  1/2/4 lanes and captures read data. It owns the qsclk_o/qcsb_o/qspi_o/qspi_oeb pins; the sequencer
//  issues back-to-back phases and controls when CS is released via last_i.
// PARAMETERS
//  DIV_W  8  width of clk_div_i; SCLK half-period H = clk_div_i+1 clk_i cycles
// PORTS
//  clk_i      in  1      system clock; only clock in the block
//  rst_i      in  1      synchronous, active-high reset
//  start_i    in  1      phase request; accepted in the cycle start_i && ready_o
//  ready_o    out 1      idle, can accept a phase
//  phase_i    in  2      0=TX, 1=RX, 2=DUMMY, 3=reserved (treated as DUMMY)
//  mode_i     in  2      0=single, 1=dual, 2=quad, 3=reserved (treated as single)
//  cycles_i   in  6      SCLK cycles in this phase (0..63)
//  last_i     in  1      release CS after this phase
//  clk_div_i  in  DIV_W  SCLK half-period select
//  tx_data_i  in  32     TX data, left-aligned (first bit(s) at [31])
//  rx_data_o  out 32     RX data, right-aligned (last sampled bits at LSBs)
//  done_o     out 1      one-cycle pulse when a phase finishes
//  qsclk_o    out 1      flash SCLK
//  qcsb_o     out 1      flash chip select, active-low
//  qspi_i     in  4      IO[3:0] input
//  qspi_o     out 4      IO[3:0] output
//  qspi_oeb   out 4      IO output enable, active-low (0 = drive)
// BEHAVIOUR
//  Reset: qsclk_o=0, qcsb_o=1, qspi_o=0, qspi_oeb=4'hF, ready_o=1, done_o=0, rx_data_o=0, FSM=IDLE.
//  Reset asserted mid-phase: all of the above on the next clk_i edge; no done_o pulse.
//  Accept: all inputs latched (incl. clk_div_i); later changes ignored. start_i while !ready_o ignored.
//  rx_data_o cleared on accept of RX phase; otherwise holds until next RX accept.
//  Lanes per SCLK b: single=1 (out IO0, in IO1), dual=2 (IO[1:0]), quad=4 (IO[3:0]).
//  FSM: IDLE, CSS, SCLK_LO, SCLK_HI, CSH, DESEL. Half-period counter counts H cycles per state.
//   IDLE: ready_o=1, qsclk_o=0. On accept at edge T: cycles_i==0 -> done_o at T+1 (goes CSH if last_i &&
//    CS low, else stays IDLE); else CS high -> CSS; CS already low -> SCLK_LO.
//   CSS: qcsb_o=0, SCLK low, first TX bits driven, H cycles -> SCLK_LO.
//   SCLK_LO: qsclk_o=0 for H cycles, TX bits stable -> SCLK_HI.
//   SCLK_HI: qsclk_o=1 for H cycles; RX samples qspi_i lanes into rx shift reg on entry (SCLK rise);
//    at exit remaining-=1; remaining>0 -> SCLK_LO, TX shift reg shifts left by b (new bits on SCLK fall);
//    remaining==0 -> last -> CSH, else IDLE with done_o and CS held low.
//   CSH: SCLK low, CS low, H cycles -> DESEL. DESEL: qcsb_o=1, H cycles -> IDLE with done_o.
//  done_o pulses in the first cycle ready_o is 1 again (same cycle, one cycle wide).
//  Pins: TX: qspi_o[b-1:0] = tx_sh[31:32-b] lane-reversed so highest bit on highest lane;
//   oeb=0 on active lanes only (single 4'b1110, dual 4'b1100, quad 4'b0000); undriven lanes qspi_o=0.
//   RX/DUMMY/IDLE/CSS-of-RX: oeb=4'hF. DUMMY: SCLK toggles, no drive, no sampling.
//  Widths: cycles_i*b > 32 -> TX shifts in zeros after 32 bits; RX keeps the last 32 bits sampled.
//  One SCLK cycle = 2H clk_i cycles; with CS low, first SCLK rise occurs H+1 cycles after accept.
// TESTING
//  Reset: hold rst_i 2 cycles -> qcsb_o=1, qsclk_o=0, qspi_oeb=F, ready_o=1, rx_data_o=0.
//  Single TX cmd: div=0, TX, single, cycles=8, tx=0xEB000000, last=0 -> CS falls, 8 SCLK pulses of
//   2 clk, IO0 at rises = 1,1,1,0,1,0,1,1, oeb=4'b1110, done_o once, CS stays low, ready_o=1.
//  Quad RX: div=1, RX, quad, cycles=8, model drives nibbles 1..8 -> rx_data_o=0x12345678, oeb=4'hF.
//  Dummy+last: div=3, DUMMY, cycles=4, last=1 -> 4 SCLK of 8 clk, oeb=F, CS low 4 clk after last
//   fall, then CS high 4 clk, then done_o; start_i pulsed while busy -> no effect.
//  Zero cycles: cycles=0, last=0 -> done_o 1 cycle after accept, no SCLK edge, pins unchanged.
//  Reset mid-shift: rst_i after 3 SCLKs of quad TX -> next edge CS=1, SCLK=0, oeb=F, ready_o=1, no done_o.

Source files
------------

// File: rtl/qspi_phy_shifter.sv
// qspi_phy_shifter
// Serial engine below the QSPI sequencer. Runs one transfer phase per start
// (TX / RX / DUMMY) in SPI mode 0 on 1, 2 or 4 lanes, owns the flash pins and
// keeps chip select low between phases until a phase marked "last" finishes.

module qspi_phy_shifter #(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    output logic             ready_o,
    input  logic [1:0]       phase_i,
    input  logic [1:0]       mode_i,
    input  logic [5:0]       cycles_i,
    input  logic             last_i,
    input  logic [DIV_W-1:0] clk_div_i,
    input  logic [31:0]      tx_data_i,
    output logic [31:0]      rx_data_o,
    output logic             done_o,
    output logic             qsclk_o,
    output logic             qcsb_o,
    input  logic [3:0]       qspi_i,
    output logic [3:0]       qspi_o,
    output logic [3:0]       qspi_oeb
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CSS,
        ST_SCLK_LO,
        ST_SCLK_HI,
        ST_CSH,
        ST_DESEL
    } state_t;

    typedef enum logic [1:0] {
        LANE_SINGLE,
        LANE_DUAL,
        LANE_QUAD
    } lane_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] halfCnt_q, halfCnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [5:0]       remaining_q, remaining_d;
    logic             last_q, last_d;
    logic             isTx_q, isTx_d;
    logic             isRx_q, isRx_d;
    lane_t            laneSel_q, laneSel_d;
    logic [31:0]      txShift_q, txShift_d;
    logic [31:0]      rxShift_q, rxShift_d;
    logic             csHeld_q, csHeld_d;
    logic             done_q, done_d;

    logic accept;
    logic halfDone;
    logic driving;

    // A phase is taken only while idle; every state lasts div+1 clocks.
    assign accept   = start_i && (state_q == ST_IDLE);
    assign halfDone = (halfCnt_q == div_q);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: chip-select setup, SCLK low/high halves, hold and deselect.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (cycles_i == 6'd0) begin
                        state_d = (last_i && csHeld_q) ? ST_CSH : ST_IDLE;
                    end else begin
                        state_d = csHeld_q ? ST_SCLK_LO : ST_CSS;
                    end
                end
            end
            ST_CSS: begin
                if (halfDone) state_d = ST_SCLK_LO;
            end
            ST_SCLK_LO: begin
                if (halfDone) state_d = ST_SCLK_HI;
            end
            ST_SCLK_HI: begin
                if (halfDone) begin
                    if (remaining_q == 6'd1) begin
                        state_d = last_q ? ST_CSH : ST_IDLE;
                    end else begin
                        state_d = ST_SCLK_LO;
                    end
                end
            end
            ST_CSH: begin
                if (halfDone) state_d = ST_DESEL;
            end
            ST_DESEL: begin
                if (halfDone) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: latch the phase on accept, sample on SCLK rise,
    // shift TX on SCLK fall, and raise done whenever the engine returns to idle.
    always_comb begin
        halfCnt_d   = halfCnt_q;
        div_d       = div_q;
        remaining_d = remaining_q;
        last_d      = last_q;
        isTx_d      = isTx_q;
        isRx_d      = isRx_q;
        laneSel_d   = laneSel_q;
        txShift_d   = txShift_q;
        rxShift_d   = rxShift_q;
        csHeld_d    = csHeld_q;
        done_d      = 1'b0;

        if ((state_q == ST_IDLE) || (state_d != state_q)) begin
            halfCnt_d = '0;
        end else begin
            halfCnt_d = halfCnt_q + DIV_W'(1);
        end

        if (accept) begin
            div_d       = clk_div_i;
            remaining_d = cycles_i;
            last_d      = last_i;
            isTx_d      = (phase_i == 2'd0);
            isRx_d      = (phase_i == 2'd1);
            txShift_d   = tx_data_i;
            case (mode_i)
                2'd1:    laneSel_d = LANE_DUAL;
                2'd2:    laneSel_d = LANE_QUAD;
                default: laneSel_d = LANE_SINGLE;
            endcase
            if (phase_i == 2'd1) begin
                rxShift_d = '0;
            end
            if ((cycles_i == 6'd0) && !(last_i && csHeld_q)) begin
                done_d = 1'b1;
            end
        end

        if ((state_q == ST_SCLK_LO) && halfDone && isRx_q) begin
            case (laneSel_q)
                LANE_DUAL: rxShift_d = {rxShift_q[29:0], qspi_i[1:0]};
                LANE_QUAD: rxShift_d = {rxShift_q[27:0], qspi_i[3:0]};
                default:   rxShift_d = {rxShift_q[30:0], qspi_i[1]};
            endcase
        end

        if ((state_q == ST_SCLK_HI) && halfDone) begin
            remaining_d = remaining_q - 6'd1;
            if (remaining_q != 6'd1) begin
                case (laneSel_q)
                    LANE_DUAL: txShift_d = {txShift_q[29:0], 2'b00};
                    LANE_QUAD: txShift_d = {txShift_q[27:0], 4'b0000};
                    default:   txShift_d = {txShift_q[30:0], 1'b0};
                endcase
            end else if (!last_q) begin
                csHeld_d = 1'b1;
                done_d   = 1'b1;
            end
        end

        if (state_q == ST_DESEL) begin
            csHeld_d = 1'b0;
            if (halfDone) begin
                done_d = 1'b1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            halfCnt_q   <= '0;
            div_q       <= '0;
            remaining_q <= '0;
            last_q      <= 1'b0;
            isTx_q      <= 1'b0;
            isRx_q      <= 1'b0;
            laneSel_q   <= LANE_SINGLE;
            txShift_q   <= '0;
            rxShift_q   <= '0;
            csHeld_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            halfCnt_q   <= halfCnt_d;
            div_q       <= div_d;
            remaining_q <= remaining_d;
            last_q      <= last_d;
            isTx_q      <= isTx_d;
            isRx_q      <= isRx_d;
            laneSel_q   <= laneSel_d;
            txShift_q   <= txShift_d;
            rxShift_q   <= rxShift_d;
            csHeld_q    <= csHeld_d;
            done_q      <= done_d;
        end
    end

    // Pin and handshake outputs decoded from the current state.
    always_comb begin
        ready_o   = (state_q == ST_IDLE);
        done_o    = done_q;
        rx_data_o = rxShift_q;
        qsclk_o   = (state_q == ST_SCLK_HI);
        qspi_o    = 4'h0;
        qspi_oeb  = 4'hF;

        case (state_q)
            ST_IDLE:  qcsb_o = !csHeld_q;
            ST_DESEL: qcsb_o = 1'b1;
            default:  qcsb_o = 1'b0;
        endcase

        driving = isTx_q && ((state_q == ST_CSS) || (state_q == ST_SCLK_LO) ||
                             (state_q == ST_SCLK_HI));
        if (driving) begin
            case (laneSel_q)
                LANE_DUAL: begin
                    qspi_oeb = 4'b1100;
                    qspi_o   = {2'b00, txShift_q[31:30]};
                end
                LANE_QUAD: begin
                    qspi_oeb = 4'b0000;
                    qspi_o   = txShift_q[31:28];
                end
                default: begin
                    qspi_oeb = 4'b1110;
                    qspi_o   = {3'b000, txShift_q[31]};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_phy_shifter.sv
// tb_qspi_phy_shifter
// Directed bench for the QSPI PHY shifter: a command TX, quad and single RX,
// dummy phase with CS release, zero-length phase and reset mid-shift.

module tb_qspi_phy_shifter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        ready_o;
    logic [1:0]  phase_i;
    logic [1:0]  mode_i;
    logic [5:0]  cycles_i;
    logic        last_i;
    logic [7:0]  clk_div_i;
    logic [31:0] tx_data_i;
    logic [31:0] rx_data_o;
    logic        done_o;
    logic        qsclk_o;
    logic        qcsb_o;
    logic [3:0]  qspi_i;
    logic [3:0]  qspi_o;
    logic [3:0]  qspi_oeb;

    int errors = 0;
    int checks = 0;

    int          nRise, nHigh, oebBad, lastFall, csRise, doneAt;
    logic [31:0] ioWord;
    logic        csbAtK1;
    logic [31:0] rxAtK1;

    qspi_phy_shifter #(.DIV_W(8)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .ready_o   (ready_o),
        .phase_i   (phase_i),
        .mode_i    (mode_i),
        .cycles_i  (cycles_i),
        .last_i    (last_i),
        .clk_div_i (clk_div_i),
        .tx_data_i (tx_data_i),
        .rx_data_o (rx_data_o),
        .done_o    (done_o),
        .qsclk_o   (qsclk_o),
        .qcsb_o    (qcsb_o),
        .qspi_i    (qspi_i),
        .qspi_o    (qspi_o),
        .qspi_oeb  (qspi_oeb)
    );

    // Free-running system clock.
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present a phase on a falling edge and hold start for exactly one rising edge.
    task automatic applyStimulus(input logic [1:0] phase, input logic [1:0] mode,
                                 input logic [5:0] cycles, input logic last,
                                 input logic [7:0] div, input logic [31:0] tx);
        @(negedge clk_i);
        phase_i   = phase;
        mode_i    = mode;
        cycles_i  = cycles;
        last_i    = last;
        clk_div_i = div;
        tx_data_i = tx;
        start_i   = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
    endtask

    // Watch the pins once per cycle (k=1 is the first cycle after accept) until
    // done_o, an optional rise count, or the cycle budget is reached.
    task automatic runMonitor(input bit driveRx, input int stopRises,
                              input logic [3:0] expOeb, input bit poke);
        logic       prevSclk;
        logic       prevCsb;
        logic [3:0] nib;
        bit         stopped;
        nRise = 0; nHigh = 0; oebBad = 0; lastFall = 0; csRise = 0; doneAt = 0;
        ioWord = '0; prevSclk = 1'b0; prevCsb = qcsb_o; nib = 4'h1; stopped = 1'b0;
        csbAtK1 = 1'b1; rxAtK1 = '0;
        for (int k = 1; k <= 3000 && doneAt == 0 && !stopped; k++) begin
            @(negedge clk_i);
            if (k == 1) begin
                csbAtK1 = qcsb_o;
                rxAtK1  = rx_data_o;
            end
            if (qsclk_o && !prevSclk) begin
                nRise++;
                ioWord = {ioWord[27:0], qspi_o};
                if (qspi_oeb !== expOeb) oebBad++;
            end
            if (qsclk_o) nHigh++;
            if (!qsclk_o && prevSclk) begin
                lastFall = k;
                if (driveRx) begin
                    nib++;
                    qspi_i = nib;
                end
            end
            if (qcsb_o && !prevCsb) csRise = k;
            if ((qspi_o & qspi_oeb) != 4'h0) oebBad++;
            if (done_o) doneAt = k;
            if (poke && k == 10) begin
                start_i   = 1'b1;
                phase_i   = 2'd0;
                cycles_i  = 6'd0;
                last_i    = 1'b0;
                clk_div_i = 8'd0;
            end
            if (poke && k == 11) start_i = 1'b0;
            prevSclk = qsclk_o;
            prevCsb  = qcsb_o;
            if (stopRises != 0 && nRise == stopRises) stopped = 1'b1;
        end
    endtask

    initial begin
        int doneSeen;
        rst_i = 1'b1; start_i = 1'b0; phase_i = 2'd0; mode_i = 2'd0; cycles_i = 6'd0;
        last_i = 1'b0; clk_div_i = 8'd0; tx_data_i = '0; qspi_i = 4'h0;

        // Reset held for two cycles.
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("rst_csb", qcsb_o, 1);
        checkOutput("rst_sclk", qsclk_o, 0);
        checkOutput("rst_oeb", qspi_oeb, 4'hF);
        checkOutput("rst_ready", ready_o, 1);
        checkOutput("rst_rx", rx_data_o, 0);
        checkOutput("rst_done", done_o, 0);
        checkOutput("rst_io", qspi_o, 0);
        rst_i = 1'b0;

        // Single-lane command 0xEB, CS initially high, kept low afterwards.
        applyStimulus(2'd0, 2'd0, 6'd8, 1'b0, 8'd0, 32'hEB00_0000);
        runMonitor(1'b0, 0, 4'b1110, 1'b0);
        checkOutput("tx_cs_fall", csbAtK1, 0);
        checkOutput("tx_rises", nRise, 8);
        checkOutput("tx_high_cycles", nHigh, 8);
        checkOutput("tx_io_bits", ioWord, 32'h1110_1011);
        checkOutput("tx_oeb", oebBad, 0);
        checkOutput("tx_done_at", doneAt, 18);
        @(negedge clk_i);
        checkOutput("tx_done_width", done_o, 0);
        checkOutput("tx_cs_held", qcsb_o, 0);
        checkOutput("tx_ready", ready_o, 1);

        // Quad read, flash model presents nibbles 1..8 changing on SCLK fall.
        qspi_i = 4'h1;
        applyStimulus(2'd1, 2'd2, 6'd8, 1'b0, 8'd1, 32'hFFFF_FFFF);
        runMonitor(1'b1, 0, 4'hF, 1'b0);
        checkOutput("qrx_rises", nRise, 8);
        checkOutput("qrx_high_cycles", nHigh, 16);
        checkOutput("qrx_oeb", oebBad, 0);
        checkOutput("qrx_done_at", doneAt, 33);
        checkOutput("qrx_data", rx_data_o, 32'h1234_5678);

        // Single read of three ones on IO1; old read data must be cleared.
        qspi_i = 4'b0010;
        applyStimulus(2'd1, 2'd0, 6'd3, 1'b0, 8'd0, 32'h0);
        runMonitor(1'b0, 0, 4'hF, 1'b0);
        checkOutput("srx_cleared", rxAtK1, 0);
        checkOutput("srx_done_at", doneAt, 7);
        checkOutput("srx_data", rx_data_o, 32'h7);

        // Dummy phase closing the transaction, with a start poked while busy.
        applyStimulus(2'd2, 2'd0, 6'd4, 1'b1, 8'd3, 32'hFFFF_FFFF);
        runMonitor(1'b0, 0, 4'hF, 1'b1);
        checkOutput("dum_rises", nRise, 4);
        checkOutput("dum_high_cycles", nHigh, 16);
        checkOutput("dum_oeb", oebBad, 0);
        checkOutput("dum_csh_len", csRise - lastFall, 4);
        checkOutput("dum_desel_len", doneAt - csRise, 4);
        checkOutput("dum_done_at", doneAt, 41);
        checkOutput("dum_cs_released", qcsb_o, 1);

        // Zero-length phase with CS high: immediate done, pins untouched.
        applyStimulus(2'd0, 2'd0, 6'd0, 1'b0, 8'd2, 32'hFFFF_FFFF);
        runMonitor(1'b0, 0, 4'hF, 1'b0);
        checkOutput("zero_done_at", doneAt, 1);
        checkOutput("zero_rises", nRise, 0);
        checkOutput("zero_csb", csbAtK1, 1);
        checkOutput("zero_oeb", oebBad, 0);

        // Quad write interrupted by reset during the third SCLK high.
        applyStimulus(2'd0, 2'd2, 6'd8, 1'b1, 8'd0, 32'hA5C3_F00F);
        runMonitor(1'b0, 3, 4'b0000, 1'b0);
        checkOutput("qtx_io_nibbles", ioWord, 32'hA5C);
        checkOutput("qtx_oeb", oebBad, 0);
        rst_i = 1'b1;
        @(negedge clk_i);
        checkOutput("mrst_csb", qcsb_o, 1);
        checkOutput("mrst_sclk", qsclk_o, 0);
        checkOutput("mrst_oeb", qspi_oeb, 4'hF);
        checkOutput("mrst_ready", ready_o, 1);
        doneSeen = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done_o) doneSeen++;
            @(negedge clk_i);
        end
        checkOutput("mrst_no_done", doneSeen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
